// File: rtl/exchange_sequencer.sv
// Iteration controller for the replica-exchange salesman array: sweep, exchange,
// settle per iteration, then a readout shift through the PREV chain.
package exchange_sequencer_pkg;
    typedef enum logic [0:0] {OR0 = 1'b0, OR1 = 1'b1} opt_command_t;
endpackage

module exchange_sequencer
    import exchange_sequencer_pkg::*;
#(
    parameter int replica_num   = 32,
    parameter int iter_w        = 24,
    parameter int settle_cycles = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [iter_w-1:0]      iter_num,
    input  logic [replica_num-1:0] sweep_done,
    output logic                   replica_run,
    output opt_command_t           opt_command,
    output logic                   exchange_run,
    output logic                   exchange_shift_d,
    output logic                   busy,
    output logic                   done,
    output logic [iter_w-1:0]      iter_cnt
);

    localparam int SW = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam int CW = (replica_num > 1) ? $clog2(replica_num) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SWEEP  = 3'd1,
        EXCH   = 3'd2,
        SETTLE = 3'd3,
        SHIFT  = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t            state, state_next;
    logic              first, first_next;
    logic [SW-1:0]     settle_cnt, settle_cnt_next;
    logic [CW-1:0]     shift_cnt, shift_cnt_next;
    logic [iter_w-1:0] iter_lim, iter_lim_next, iter_cnt_next, iter_inc;
    opt_command_t      opt_next;
    logic              replica_run_next, exchange_run_next, shift_next, done_next;

    assign iter_inc = iter_cnt + {{(iter_w-1){1'b0}}, 1'b1};

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_next        = state;
        first_next        = 1'b0;
        settle_cnt_next   = settle_cnt;
        shift_cnt_next    = shift_cnt;
        iter_lim_next     = iter_lim;
        iter_cnt_next     = iter_cnt;
        opt_next          = opt_command;
        replica_run_next  = 1'b0;
        exchange_run_next = 1'b0;
        shift_next        = 1'b0;
        done_next         = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_lim_next = iter_num;
                        iter_cnt_next = '0;
                        opt_next      = OR0;
                        if (iter_num != '0) begin
                            state_next       = SWEEP;
                            replica_run_next = 1'b1;
                            first_next       = 1'b1;
                        end else begin
                            state_next        = SHIFT;
                            shift_next        = 1'b1;
                            exchange_run_next = 1'b1;
                            shift_cnt_next    = CW'(replica_num - 1);
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                SWEEP: begin
                    // The first cycle may still see done bits left over from the previous sweep.
                    if (!first && (&sweep_done)) begin
                        state_next        = EXCH;
                        exchange_run_next = 1'b1;
                    end else begin
                        replica_run_next = 1'b1;
                    end
                end
                EXCH: begin
                    state_next      = SETTLE;
                    settle_cnt_next = SW'(settle_cycles - 1);
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        iter_cnt_next = iter_inc;
                        opt_next      = (opt_command == OR0) ? OR1 : OR0;
                        if (iter_inc == iter_lim) begin
                            state_next        = SHIFT;
                            shift_next        = 1'b1;
                            exchange_run_next = 1'b1;
                            shift_cnt_next    = CW'(replica_num - 1);
                        end else begin
                            state_next       = SWEEP;
                            replica_run_next = 1'b1;
                            first_next       = 1'b1;
                        end
                    end else begin
                        settle_cnt_next = settle_cnt - {{(SW-1){1'b0}}, 1'b1};
                    end
                end
                SHIFT: begin
                    if (shift_cnt == '0) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end else begin
                        shift_next     = 1'b1;
                        shift_cnt_next = shift_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIN: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            first            <= 1'b0;
            settle_cnt       <= '0;
            shift_cnt        <= '0;
            iter_lim         <= '0;
            iter_cnt         <= '0;
            opt_command      <= OR0;
            replica_run      <= 1'b0;
            exchange_run     <= 1'b0;
            exchange_shift_d <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_next;
            first            <= first_next;
            settle_cnt       <= settle_cnt_next;
            shift_cnt        <= shift_cnt_next;
            iter_lim         <= iter_lim_next;
            iter_cnt         <= iter_cnt_next;
            opt_command      <= opt_next;
            replica_run      <= replica_run_next;
            exchange_run     <= exchange_run_next;
            exchange_shift_d <= shift_next;
            busy             <= (state_next != IDLE);
            done             <= done_next;
        end
    end

endmodule

// File: tb/tb_exchange_sequencer.sv
// Scoreboard bench for exchange_sequencer: expected exchange/shift/done events are
// queued by the stimulus and popped by an independent monitor.
module tb_exchange_sequencer;
    import exchange_sequencer_pkg::*;

    localparam int RN = 32;
    localparam int IW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] iter_num = '0;
    logic [RN-1:0] sweep_done;
    logic          replica_run, exchange_run, exchange_shift_d, busy, done;
    opt_command_t  opt_command;
    logic [IW-1:0] iter_cnt;

    exchange_sequencer #(.replica_num(RN), .iter_w(IW), .settle_cycles(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .iter_num(iter_num),
        .sweep_done(sweep_done), .replica_run(replica_run), .opt_command(opt_command),
        .exchange_run(exchange_run), .exchange_shift_d(exchange_shift_d), .busy(busy),
        .done(done), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 = iteration exchange (opt, replica_run length), 1 = shift-start exchange,
    //       2 = shift length, 3 = done (iter_cnt)
    typedef struct {
        int kind;
        int opt;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  lane_delay[RN];
    int  rr_cycles = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input int opt, input int val);
        ev_t e;
        e.kind = kind;
        e.opt  = opt;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input int n, input int run_len);
        for (int i = 0; i < n; i++) push(0, i % 2, run_len);
        push(1, 0, 0);
        push(2, 0, RN);
        push(3, 0, n);
    endtask

    task automatic compare_event(input int kind, input int opt, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d opt %0d val %0d, queue empty", kind, opt, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.opt != opt || e.val != val) begin
                n_fail++;
                $display("FAIL event: got kind %0d opt %0d val %0d expected kind %0d opt %0d val %0d",
                         kind, opt, val, e.kind, e.opt, e.val);
            end
        end
    endtask

    task automatic set_delays(input int base, input int slow_lane, input int slow_delay);
        for (int i = 0; i < RN; i++) lane_delay[i] = (i == slow_lane) ? slow_delay : base;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        iter_num = IW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic wait_sweep(input int it, input int budget);
        int k;
        k = 0;
        while (!(replica_run && iter_cnt == IW'(it)) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!(replica_run && iter_cnt == IW'(it))) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_sweep: sweep of iteration %0d not seen in %0d cycles", it, budget);
        end
    endtask

    // Lane model: each lane raises its done bit lane_delay cycles after replica_run rises.
    initial begin
        int  since;
        logic rr_q;
        since = 0;
        rr_q = 1'b0;
        sweep_done = '0;
        forever begin
            @(negedge clk);
            if (replica_run && !rr_q) begin
                since = 0;
                sweep_done = '0;
            end else begin
                since++;
            end
            rr_q = replica_run;
            for (int i = 0; i < RN; i++)
                if (replica_run && since >= lane_delay[i]) sweep_done[i] = 1'b1;
        end
    end

    // Monitor: turns DUT output activity into events and checks them against the queue.
    initial begin
        int run_len;
        int shift_len;
        run_len = 0;
        shift_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_len = 0;
                shift_len = 0;
            end else begin
                if (replica_run) begin
                    run_len++;
                    rr_cycles++;
                end
                if (exchange_shift_d) shift_len++;
                else if (shift_len != 0) begin
                    compare_event(2, 0, shift_len);
                    shift_len = 0;
                end
                if (exchange_run) begin
                    if (exchange_shift_d) compare_event(1, 0, 0);
                    else compare_event(0, int'(opt_command), run_len);
                    run_len = 0;
                end
                if (done) compare_event(3, 0, int'(iter_cnt));
                if (!busy) run_len = 0;
            end
        end
    end

    initial begin
        int rr_before;
        int k;
        set_delays(5, 0, 5);
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_replica_run", int'(replica_run), 0);
        check("reset_shift", int'(exchange_shift_d), 0);
        check("reset_iter_cnt", int'(iter_cnt), 0);
        check("reset_opt", int'(opt_command), 0);
        reset = 1'b0;

        // 1: four iterations, all lanes done 5 cycles into each sweep
        push_run(4, 6);
        pulse_start(4);
        wait_idle(1000);
        check("t1_iter_cnt", int'(iter_cnt), 4);
        check("t1_opt", int'(opt_command), int'(OR0));

        // 2: lane 7 is 100 cycles late
        set_delays(5, 7, 100);
        push_run(2, 101);
        pulse_start(2);
        wait_idle(1000);
        check("t2_iter_cnt", int'(iter_cnt), 2);
        set_delays(5, 0, 5);

        // 3: zero iterations goes straight to the shift
        rr_before = rr_cycles;
        push_run(0, 0);
        pulse_start(0);
        wait_idle(200);
        check("t3_no_sweep", rr_cycles - rr_before, 0);
        check("t3_iter_cnt", int'(iter_cnt), 0);

        // 4: abort during the sweep of iteration 2, then a clean one-iteration run
        push(0, 0, 6);
        push(0, 1, 6);
        pulse_start(4);
        wait_sweep(2, 500);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy", int'(busy), 0);
        check("t4_replica_run", int'(replica_run), 0);
        check("t4_iter_cnt", int'(iter_cnt), 2);
        repeat (3) @(negedge clk);
        check("t4_still_idle", int'(busy), 0);
        push_run(1, 6);
        pulse_start(1);
        wait_idle(500);
        check("t4_rerun_iter_cnt", int'(iter_cnt), 1);

        // 5a: start while busy is ignored
        push_run(2, 6);
        pulse_start(2);
        repeat (2) @(negedge clk);
        start = 1'b1;
        iter_num = IW'(9);
        @(negedge clk);
        start = 1'b0;
        wait_idle(1000);
        check("t5_busy_start_iter_cnt", int'(iter_cnt), 2);

        // 5b: start together with abort mid-run lands in IDLE
        push(0, 0, 6);
        pulse_start(3);
        wait_sweep(1, 500);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        iter_num = IW'(5);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_iter_cnt", int'(iter_cnt), 1);
        push_run(1, 6);
        pulse_start(1);
        wait_idle(500);
        check("t5_rerun_iter_cnt", int'(iter_cnt), 1);

        // 6: asynchronous reset at shift cycle 10
        push(0, 0, 6);
        push(1, 0, 0);
        pulse_start(1);
        k = 0;
        while (!exchange_shift_d && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_shift_seen", int'(exchange_shift_d), 1);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_shift", int'(exchange_shift_d), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_exchange_run", int'(exchange_run), 0);
        check("t6_replica_run", int'(replica_run), 0);
        check("t6_done", int'(done), 0);
        check("t6_iter_cnt", int'(iter_cnt), 0);
        check("t6_opt", int'(opt_command), int'(OR0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_stays_idle", int'(busy), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
